mrc: RTL and testbench
======================

Name: mrc

Overview:
- Parametrised multi-digit, multi-radix up/down counter.
- Each digit counts in either decimal (0-9) or hexadecimal (0-F), chosen at run time by a mode input. Digits ripple carry/borrow into the next digit within the same cycle.
- Sits between the clock-divider tick and the seven-segment display driver. It feeds DIGITS nibbles to the display scanner.
- Replaces the separate decimal/hex counters plus output mux with one counter that adds direction, parallel load and wrap indication.

Parameters:
DIGITS, 4, number of 4-bit digits (1..8); output width = 4*DIGITS
DEC_CLAMP, 1, 1 = loaded digits >9 saturate to 9 in decimal mode; 0 = loaded unchanged

Ports:
mrc_clk  input  1  clock, rising-edge
mrc_rst  input  1  reset, synchronous, active-high
mrc_en  input  1  count enable; one step per clock while high (single-cycle tick from divider)
mrc_mode  input  1  1 = decimal (max digit 9), 0 = hexadecimal (max digit F)
mrc_dir  input  1  1 = count up, 0 = count down
mrc_ld  input  1  synchronous parallel load
mrc_d  input  4*DIGITS  load value, digit 0 in bits [3:0]
mrc_q  output  4*DIGITS  current count, digit 0 in bits [3:0]
mrc_wrap  output  1  registered one-cycle pulse: the previous step wrapped the whole counter

Behaviour:
- One clock (mrc_clk); reset is synchronous and active-high (mrc_rst).
- Reset: mrc_q = 0, mrc_wrap = 0. Reset overrides ld and en in the same cycle.
- Priority: rst > ld > en. With none of these asserted, mrc_q holds and mrc_wrap = 0.
- Load (mrc_ld=1):
  - mrc_q <= mrc_d, applied per digit.
  - In decimal mode with DEC_CLAMP=1, any digit >9 is stored as 9.
  - mrc_wrap <= 0.
  - mrc_en is ignored that cycle.
- Step (mrc_en=1, no ld): let MAX = 9 if mode=1, else 15. Digit 0 always receives step-in = 1.
- Up step, for each digit with step-in=1:
  - If digit >= MAX: next = 0, carry-out = 1.
  - Otherwise: next = digit+1, carry-out = 0.
- Down step, for each digit with step-in=1:
  - If digit == 0: next = MAX, borrow-out = 1.
  - If digit > MAX (only possible after a hex-to-decimal mode switch): next = MAX, borrow-out = 0.
  - Otherwise: next = digit-1, borrow-out = 0.
- A digit with step-in=0 holds its value.
- Step-in of digit i+1 = carry/borrow-out of digit i. The whole chain is combinational and completes in one cycle; latency is one clock from en to the mrc_q update.
- Wrap:
  - Carry/borrow out of the top digit means a whole-counter wrap. Up example: 9999 -> 0000. Down example: 0000 -> 9999 (or FFFF in hex).
  - mrc_wrap is registered, high for exactly the one cycle in which mrc_q shows the wrapped value. It is low otherwise.
- Mode and dir changes take effect on the next step; no state is cleared.
- Mode switch hex->decimal with digits A-F:
  - The next up step wraps the affected digit to 0 with carry.
  - The next down step saturates it to 9 with no borrow.
- Reset asserted in the middle of a count, with en held high: the next edge gives mrc_q = 0. Counting resumes from 0 on the first edge after rst deasserts.
- DIGITS=1: mrc_wrap follows the single digit's carry/borrow.

Decomposition:
- Package mrc_pkg holds:
  - DIGIT_W = 4.
  - MODE_HEX = 0, MODE_DEC = 1.
  - DIR_DOWN = 0, DIR_UP = 1.
  - MAX_HEX = 4'hF, MAX_DEC = 4'd9.
- Sub-module mrc_digit: combinational single-digit cell.
  - Inputs: digit, step_in, mode, dir.
  - Outputs: next digit, step_out.
- Top level:
  - Generates DIGITS instances chained via step_in/step_out.
  - Holds the 4*DIGITS state register, load/clamp logic and the mrc_wrap flop.

Test Plan:
- DIGITS=4, dec, up, en every cycle, starting from reset: after 10 steps mrc_q=0010. Load 9998, then 2 steps: 9999, then 0000 with mrc_wrap=1 for exactly that cycle.
- Hex, down, starting from reset: 1 step gives mrc_q=FFFF with mrc_wrap=1. Load 0100 and step once: 00FF, mrc_wrap=0.
- Dec, DEC_CLAMP=1, load mrc_d=3A7F: mrc_q=3979. Hex with the same load: mrc_q=3A7F.
- Hex, load 00AC, switch to dec: up step gives 0100 (C wraps to 0 and carries; A wraps to 0 and carries into digit 2). Reload 00AC in hex, switch to dec, down step: 00A9 (C saturates to 9, no borrow).
- Simultaneous events:
  - ld=1 and en=1 with mrc_d=1234: mrc_q=1234, no step applied.
  - rst=1, ld=1, en=1 together: mrc_q=0000, mrc_wrap=0.
  - rst pulsed while counting at 0457 with en held: next edge gives 0000, the following edge 0001.
- DIGITS=1, dec, up from 8: 9, then 0 with mrc_wrap=1. en=0 for 3 cycles: value holds, mrc_wrap=0.

Source files
------------

// File: rtl/mrc_pkg.sv
// Shared constants for the multi-radix counter: digit width, mode/direction
// encodings and per-radix digit maxima.
package mrc_pkg;

    localparam int DIGIT_W = 4;

    localparam logic MODE_HEX = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam logic [DIGIT_W-1:0] MAX_HEX = 4'hF;
    localparam logic [DIGIT_W-1:0] MAX_DEC = 4'd9;

    function automatic logic [DIGIT_W-1:0] digit_max(input logic mode);
        return (mode == MODE_DEC) ? MAX_DEC : MAX_HEX;
    endfunction

endpackage

// File: rtl/mrc_digit.sv
// Combinational single-digit cell: steps one digit up or down in the selected
// radix and produces the carry/borrow into the next digit.
module mrc_digit
    import mrc_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               step_in,
    input  logic               mode,
    input  logic               dir,
    output logic [DIGIT_W-1:0] next,
    output logic               step_out
);

    logic [DIGIT_W-1:0] max_val;

    assign max_val = digit_max(mode);

    always_comb begin
        next     = digit;
        step_out = 1'b0;
        if (step_in) begin
            if (dir == DIR_UP) begin
                // ">=" also folds hex digits A-F left over after a switch to decimal
                if (digit >= max_val) begin
                    next     = '0;
                    step_out = 1'b1;
                end else begin
                    next = digit + 4'd1;
                end
            end else begin
                if (digit == '0) begin
                    next     = max_val;
                    step_out = 1'b1;
                end else if (digit > max_val) begin
                    next = max_val;
                end else begin
                    next = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mrc.sv
// Multi-digit up/down counter with run-time decimal/hex radix, parallel load
// and a registered whole-counter wrap pulse.
module mrc
    import mrc_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter bit DEC_CLAMP = 1'b1
) (
    input  logic                          mrc_clk,
    input  logic                          mrc_rst,
    input  logic                          mrc_en,
    input  logic                          mrc_mode,
    input  logic                          mrc_dir,
    input  logic                          mrc_ld,
    input  logic [DIGIT_W*DIGITS-1:0]     mrc_d,
    output logic [DIGIT_W*DIGITS-1:0]     mrc_q,
    output logic                          mrc_wrap
);

    logic [DIGIT_W*DIGITS-1:0] cnt_p0;
    logic [DIGIT_W*DIGITS-1:0] step_val;
    logic [DIGIT_W*DIGITS-1:0] load_val;
    logic [DIGITS:0]           step;
    logic                      wrap_p0;

    function automatic logic [DIGIT_W-1:0] sat_load(input logic [DIGIT_W-1:0] d,
                                                   input logic mode);
        if (DEC_CLAMP && (mode == MODE_DEC) && (d > MAX_DEC))
            return MAX_DEC;
        return d;
    endfunction

    assign step[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        mrc_digit u_digit (
            .digit    (cnt_p0[i*DIGIT_W +: DIGIT_W]),
            .step_in  (step[i]),
            .mode     (mrc_mode),
            .dir      (mrc_dir),
            .next     (step_val[i*DIGIT_W +: DIGIT_W]),
            .step_out (step[i+1])
        );
    end

    always_comb begin
        load_val = '0;
        for (int i = 0; i < DIGITS; i++)
            load_val[i*DIGIT_W +: DIGIT_W] = sat_load(mrc_d[i*DIGIT_W +: DIGIT_W], mrc_mode);
    end

    // Stage p0: count state and wrap flag; carry out of the top digit is the wrap
    always_ff @(posedge mrc_clk) begin
        if (mrc_rst) begin
            cnt_p0  <= '0;
            wrap_p0 <= 1'b0;
        end else if (mrc_ld) begin
            cnt_p0  <= load_val;
            wrap_p0 <= 1'b0;
        end else if (mrc_en) begin
            cnt_p0  <= step_val;
            wrap_p0 <= step[DIGITS];
        end else begin
            wrap_p0 <= 1'b0;
        end
    end

    assign mrc_q    = cnt_p0;
    assign mrc_wrap = wrap_p0;

endmodule

// File: tb/tb_mrc.sv
// Self-checking bench for mrc: three instances (4 digits clamped, 4 digits
// unclamped, 1 digit) against a digit-list reference model plus literal checks.
module tb_mrc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic        dir = 1'b1;
    logic        ld = 1'b0;
    logic [15:0] d = '0;

    logic [15:0] q4, q4n;
    logic [3:0]  q1;
    logic        w4, w4n, w1;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    logic [31:0] m4, m4n, m1;
    logic        mw4, mw4n, mw1;

    always #5 clk = ~clk;

    mrc #(.DIGITS(4), .DEC_CLAMP(1'b1)) u4 (
        .mrc_clk(clk), .mrc_rst(rst), .mrc_en(en), .mrc_mode(mode), .mrc_dir(dir),
        .mrc_ld(ld), .mrc_d(d), .mrc_q(q4), .mrc_wrap(w4));

    mrc #(.DIGITS(4), .DEC_CLAMP(1'b0)) u4n (
        .mrc_clk(clk), .mrc_rst(rst), .mrc_en(en), .mrc_mode(mode), .mrc_dir(dir),
        .mrc_ld(ld), .mrc_d(d), .mrc_q(q4n), .mrc_wrap(w4n));

    mrc #(.DIGITS(1), .DEC_CLAMP(1'b1)) u1 (
        .mrc_clk(clk), .mrc_rst(rst), .mrc_en(en), .mrc_mode(mode), .mrc_dir(dir),
        .mrc_ld(ld), .mrc_d(d[3:0]), .mrc_q(q1), .mrc_wrap(w1));

    // Reference step: returns {wrap, value}. Trailing digits at their limit
    // roll over; the first digit not at its limit absorbs the step.
    function automatic logic [32:0] mstep(input logic [31:0] v, input int n,
                                          input logic md, input logic up);
        logic [31:0] r;
        int mx;
        bit done;
        int dg;
        r = v;
        mx = md ? 9 : 15;
        done = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (!done) begin
                dg = int'(v[4*k +: 4]);
                if (up) begin
                    if (dg >= mx) r[4*k +: 4] = 4'd0;
                    else begin r[4*k +: 4] = 4'(dg + 1); done = 1'b1; end
                end else begin
                    if (dg == 0) r[4*k +: 4] = 4'(mx);
                    else begin
                        r[4*k +: 4] = (dg > mx) ? 4'(mx) : 4'(dg - 1);
                        done = 1'b1;
                    end
                end
            end
        end
        return {!done, r};
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] v, input int n,
                                          input logic md, input bit clamp);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++)
            r[4*k +: 4] = (clamp && md && v[4*k +: 4] > 4'd9) ? 4'd9 : v[4*k +: 4];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m4 <= '0; m4n <= '0; m1 <= '0;
            mw4 <= 1'b0; mw4n <= 1'b0; mw1 <= 1'b0;
        end else if (ld) begin
            m4  <= mload({16'h0, d}, 4, mode, 1'b1);
            m4n <= mload({16'h0, d}, 4, mode, 1'b0);
            m1  <= mload({28'h0, d[3:0]}, 1, mode, 1'b1);
            mw4 <= 1'b0; mw4n <= 1'b0; mw1 <= 1'b0;
        end else if (en) begin
            {mw4, m4}   <= mstep(m4, 4, mode, dir);
            {mw4n, m4n} <= mstep(m4n, 4, mode, dir);
            {mw1, m1}   <= mstep(m1, 1, mode, dir);
        end else begin
            mw4 <= 1'b0; mw4n <= 1'b0; mw1 <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model q4",   {16'h0, q4},  m4);
            check("model w4",   {31'h0, w4},  {31'h0, mw4});
            check("model q4n",  {16'h0, q4n}, m4n);
            check("model w4n",  {31'h0, w4n}, {31'h0, mw4n});
            check("model q1",   {28'h0, q1},  m1);
            check("model w1",   {31'h0, w1},  {31'h0, mw1});
        end
    end

    task automatic cyc(input logic r, input logic l, input logic e,
                       input logic md, input logic up, input logic [15:0] dv);
        rst = r; ld = l; en = e; mode = md; dir = up; d = dv;
        @(posedge clk);
        #2;
    endtask

    initial begin
        @(posedge clk); #2;
        cyc(1, 0, 0, 1, 1, 16'h0);
        started = 1'b1;
        check("reset q", {16'h0, q4}, 32'h0);
        check("reset wrap", {31'h0, w4}, 32'h0);

        // decimal up from reset
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 1, 16'h0);
        check("dec up 10", {16'h0, q4}, 32'h0010);
        cyc(0, 1, 0, 1, 1, 16'h9998);
        cyc(0, 0, 1, 1, 1, 16'h0);
        check("dec 9999", {16'h0, q4}, 32'h9999);
        check("dec 9999 nowrap", {31'h0, w4}, 32'h0);
        cyc(0, 0, 1, 1, 1, 16'h0);
        check("dec wrap q", {16'h0, q4}, 32'h0000);
        check("dec wrap pulse", {31'h0, w4}, 32'h1);
        cyc(0, 0, 0, 1, 1, 16'h0);
        check("wrap one cycle", {31'h0, w4}, 32'h0);

        // hex down
        cyc(1, 0, 0, 0, 0, 16'h0);
        cyc(0, 0, 1, 0, 0, 16'h0);
        check("hex down wrap q", {16'h0, q4}, 32'hFFFF);
        check("hex down wrap", {31'h0, w4}, 32'h1);
        cyc(0, 1, 0, 0, 0, 16'h0100);
        cyc(0, 0, 1, 0, 0, 16'h0);
        check("hex borrow q", {16'h0, q4}, 32'h00FF);
        check("hex borrow nowrap", {31'h0, w4}, 32'h0);

        // load clamp
        cyc(0, 1, 0, 1, 1, 16'h3A7F);
        check("dec clamp", {16'h0, q4}, 32'h3979);
        check("dec no clamp", {16'h0, q4n}, 32'h3A7F);
        cyc(0, 1, 0, 0, 1, 16'h3A7F);
        check("hex load", {16'h0, q4}, 32'h3A7F);

        // hex->dec mode switch
        cyc(0, 1, 0, 0, 1, 16'h00AC);
        cyc(0, 0, 1, 1, 1, 16'h0);
        check("switch up", {16'h0, q4}, 32'h0100);
        cyc(0, 1, 0, 0, 1, 16'h00AC);
        cyc(0, 0, 1, 1, 0, 16'h0);
        check("switch down", {16'h0, q4}, 32'h00A9);

        // simultaneous events
        cyc(0, 1, 1, 1, 1, 16'h1234);
        check("ld beats en", {16'h0, q4}, 32'h1234);
        cyc(1, 1, 1, 1, 1, 16'h5678);
        check("rst beats all q", {16'h0, q4}, 32'h0);
        check("rst beats all w", {31'h0, w4}, 32'h0);
        cyc(0, 1, 0, 1, 1, 16'h0457);
        cyc(1, 0, 1, 1, 1, 16'h0);
        check("rst mid count", {16'h0, q4}, 32'h0);
        cyc(0, 0, 1, 1, 1, 16'h0);
        check("resume after rst", {16'h0, q4}, 32'h0001);

        // single digit instance
        cyc(0, 1, 0, 1, 1, 16'h0008);
        cyc(0, 0, 1, 1, 1, 16'h0);
        check("d1 nine", {28'h0, q1}, 32'h9);
        cyc(0, 0, 1, 1, 1, 16'h0);
        check("d1 wrap q", {28'h0, q1}, 32'h0);
        check("d1 wrap", {31'h0, w1}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 1, 16'h0);
            check("d1 hold q", {28'h0, q1}, 32'h0);
            check("d1 hold w", {31'h0, w1}, 32'h0);
        end

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 70) ? mode : ~mode,
                ($urandom_range(0, 99) < 90) ? dir : ~dir,
                16'($urandom));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
